tick_enable_generator: RTL and testbench

//  Programmable prescaler producing single-cycle enable ticks for the modulo-N counter stage

---
 rtl/tick_enable_generator.sv | 76 +++++++
 tb/tb_tick_enable_generator.sv | 112 +++++++++++
 2 files changed

// File: rtl/tick_enable_generator.sv
// tick_enable_generator: programmable prescaler issuing 1-cycle enable ticks, continuous or finite burst.
// Define TICK_FIRST_IMMEDIATE_EN to emit the first tick right after the start edge.
module tick_enable_generator #(
    parameter int DIV_WIDTH   = 16,
    parameter int BURST_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [DIV_WIDTH-1:0]   i_div_value,
    input  logic [BURST_WIDTH-1:0] i_burst_len,
    output logic                   o_tick,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [BURST_WIDTH-1:0] o_tick_count
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t                 r_state;
    logic [DIV_WIDTH-1:0]   r_div, r_pre;
    logic [BURST_WIDTH-1:0] r_burst, r_count;
    logic                   r_tick, r_busy, r_done;
    logic [DIV_WIDTH-1:0]   w_div_in;
    logic [BURST_WIDTH-1:0] w_next_count;
    logic                   w_wrap, w_last;
    always_comb begin
        w_div_in     = (i_div_value == '0) ? DIV_WIDTH'(1) : i_div_value;
        w_next_count = r_count + 1'b1;
        w_wrap       = r_pre == r_div - 1'b1;
        w_last       = (r_burst != '0) && (w_next_count == r_burst);
    end
    // Done stays in RUN for its own cycle so busy covers the final tick.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_pre   <= '0;
            r_burst <= '0;
            r_count <= '0;
            r_tick  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (i_start && !i_stop) begin
                    r_state <= RUN;
                    r_busy  <= 1'b1;
                    r_div   <= w_div_in;
                    r_burst <= i_burst_len;
                    r_count <= '0;
`ifdef TICK_FIRST_IMMEDIATE_EN
                    r_pre   <= w_div_in - 1'b1;
`else
                    r_pre   <= '0;
`endif
                end
            end else if (i_stop || r_done) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else if (w_wrap) begin
                r_pre   <= '0;
                r_tick  <= 1'b1;
                r_count <= w_next_count;
                r_done  <= w_last;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end
    assign o_tick       = r_tick;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_tick_count = r_count;
endmodule

// File: tb/tb_tick_enable_generator.sv
// tb_tick_enable_generator: directed and random runs checked against an elapsed-cycle reference model.
module tb_tick_enable_generator;
    logic        clk = 1'b0;
    logic        rst, start, stop;
    logic [15:0] div_value;
    logic [7:0]  burst_len;
    logic        tick, busy, done;
    logic [7:0]  tick_count;
    int n_chk = 0, n_pass = 0;
    int m_run = 0, m_k = 0, m_d = 1, m_b = 0, m_cnt = 0, m_tick = 0, m_busy = 0, m_done = 0;
    int ds = 0;

    tick_enable_generator dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_stop(stop),
        .i_div_value(div_value), .i_burst_len(burst_len),
        .o_tick(tick), .o_busy(busy), .o_done(done), .o_tick_count(tick_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Expected outputs come from time elapsed since the start edge: tick n lands at first+(n-1)*D.
    task automatic model_edge(input int s, input int p, input int d, input int b, input int r);
        int first;
        if (r != 0) begin
            m_run = 0; m_cnt = 0; m_tick = 0; m_busy = 0; m_done = 0;
        end else if (m_run != 0) begin
            if (p != 0 || m_done != 0) begin
                m_run = 0; m_tick = 0; m_busy = 0; m_done = 0;
            end else begin
                m_k++;
`ifdef TICK_FIRST_IMMEDIATE_EN
                first = 1;
`else
                first = m_d;
`endif
                m_tick = (m_k >= first && (m_k - first) % m_d == 0) ? 1 : 0;
                if (m_tick != 0) m_cnt = (m_cnt + 1) % 256;
                m_done = (m_tick != 0 && m_b != 0 && m_cnt == m_b) ? 1 : 0;
                m_busy = 1;
            end
        end else if (s != 0 && p == 0) begin
            m_run = 1; m_k = 0; m_d = (d == 0) ? 1 : d; m_b = b; m_cnt = 0;
            m_tick = 0; m_done = 0; m_busy = 1;
        end else begin
            m_tick = 0; m_done = 0; m_busy = 0;
        end
    endtask

    task automatic cyc(input int s, input int p, input int d, input int b, input int r);
        start = s[0]; stop = p[0]; div_value = d[15:0]; burst_len = b[7:0]; rst = r[0];
        @(posedge clk);
        model_edge(s, p, d, b, r);
        @(negedge clk);
        if (tick) ds = (ds + 1) % 10;
        chk("tick", int'(tick), m_tick);
        chk("busy", int'(busy), m_busy);
        chk("done", int'(done), m_done);
        chk("tick_count", int'(tick_count), m_cnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; stop = 1'b0; div_value = '0; burst_len = '0;
        @(negedge clk);
        cyc(1, 0, 4, 3, 1);
        cyc(1, 0, 4, 3, 1);
        chk("reset_tick", int'(tick), 0);
        chk("reset_busy", int'(busy), 0);
        // Finite burst D=4, B=3
        ds = 0;
        cyc(1, 0, 4, 3, 0);
        idle(14);
        chk("burst_final_count", int'(tick_count), 3);
        chk("burst_busy_off", int'(busy), 0);
        chk("downstream_mod10", ds, 3);
        // Continuous D=1 through count wrap
        cyc(1, 0, 0, 0, 0);
        idle(300);
        cyc(0, 1, 0, 0, 0);
        idle(3);
        // Stop mid-burst
        cyc(1, 0, 5, 10, 0);
        idle(11);
        cyc(0, 1, 0, 0, 0);
        idle(6);
        chk("stopped_count", int'(tick_count), 2);
        // Start with stop in IDLE, then restart attempt in RUN
        cyc(1, 1, 4, 0, 0);
        chk("start_stop_idle", int'(busy), 0);
        cyc(1, 0, 4, 0, 0);
        idle(5);
        cyc(1, 0, 2, 1, 0);
        idle(20);
        cyc(0, 1, 0, 0, 0);
        idle(2);
        // Random traffic
        for (int i = 0; i < 2000; i++)
            cyc(($urandom_range(0, 9) == 0) ? 1 : 0, ($urandom_range(0, 39) == 0) ? 1 : 0,
                $urandom_range(0, 6), $urandom_range(0, 5), ($urandom_range(0, 299) == 0) ? 1 : 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
